// File: rtl/clock_divider_prog_if.sv
// Load handshake bundle for the programmable divider.
// Master requests a new mode/divisor/high-time; slave answers with ready.
interface clock_divider_prog_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       Mode;
  logic [WIDTH-1:0] Div_in;
  logic [WIDTH-1:0] High_in;
  logic             Load_valid;
  logic             Load_ready;

  modport master (
    output Mode,
    output Div_in,
    output High_in,
    output Load_valid,
    input  Load_ready
  );

  modport slave (
    input  Mode,
    input  Div_in,
    input  High_in,
    input  Load_valid,
    output Load_ready
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock/tick generator (toggle, pulse, PWM).
// New settings wait in a shadow and switch in at period boundaries.
module clock_divider_prog #(
  parameter int WIDTH        = 16,
  parameter int DIV_DEFAULT  = 12500,
  parameter int HIGH_DEFAULT = 6250,
  parameter int MODE_DEFAULT = 0
) (
  input  logic Clk_in,
  input  logic Rst_n,
  input  logic Enable,
  clock_divider_prog_if.slave ld,
  output logic Clk_out,
  output logic Tick
);

  localparam logic [WIDTH-1:0] L_DIV  = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] L_HIGH = WIDTH'(HIGH_DEFAULT);
  localparam logic [1:0]       L_MODE = 2'(MODE_DEFAULT);
  localparam logic [WIDTH-1:0] L_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_high;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_sdiv;
  logic [WIDTH-1:0] r_shigh;
  logic [1:0]       r_smode;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;

  logic             w_acc;
  logic             w_term;
  logic             w_apply;
  logic [WIDTH-1:0] w_div_in;
  logic [WIDTH-1:0] w_high_n;
  logic [1:0]       w_mode_n;
  logic             w_pulse;
  logic             w_pwm;
  logic [WIDTH-1:0] w_cnt_n;
  logic             w_clk_n;
  logic             w_tick_n;

  assign ld.Load_ready = ~r_pend;
  assign Clk_out       = r_clk;
  assign Tick          = r_tick;

  assign w_acc    = ld.Load_valid & ~r_pend;
  assign w_term   = Enable & (r_cnt == r_div - L_ONE);
  assign w_apply  = r_pend & (w_term | ~Enable);
  assign w_div_in = (ld.Div_in == '0) ? L_ONE : ld.Div_in;
  assign w_high_n = w_apply ? r_shigh : r_high;
  assign w_mode_n = w_apply ? r_smode : r_mode;
  assign w_pulse  = (w_mode_n == 2'd1);
  assign w_pwm    = (w_mode_n == 2'd2);

  // Next counter, strobe and output level for the coming cycle
  always_comb begin
    w_cnt_n  = '0;
    w_clk_n  = 1'b0;
    w_tick_n = 1'b0;
    if (Enable) begin
      w_tick_n = w_term;
      w_cnt_n  = w_term ? '0 : r_cnt + L_ONE;
      unique case (1'b1)
        w_pulse: w_clk_n = w_term;
        w_pwm:   w_clk_n = (w_cnt_n < w_high_n);
        default: w_clk_n = w_term ? ~r_clk : r_clk;
      endcase
    end
  end

  // Counter, outputs, shadow capture and boundary apply
  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
      r_pend  <= 1'b0;
      r_div   <= L_DIV;
      r_high  <= L_HIGH;
      r_mode  <= L_MODE;
      r_sdiv  <= L_DIV;
      r_shigh <= L_HIGH;
      r_smode <= L_MODE;
    end else begin
      r_cnt  <= w_cnt_n;
      r_clk  <= w_clk_n;
      r_tick <= w_tick_n;
      if (w_apply) begin
        r_div  <= r_sdiv;
        r_high <= r_shigh;
        r_mode <= r_smode;
        r_pend <= 1'b0;
      end
      if (w_acc) begin
        r_sdiv  <= w_div_in;
        r_shigh <= ld.High_in;
        r_smode <= ld.Mode;
        r_pend  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: directed waveforms queued per cycle,
// a negedge monitor pops and compares Tick/Clk_out/Load_ready.
module tb_clock_divider_prog;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic en;
  logic clk_out;
  logic tick;

  clock_divider_prog_if #(.WIDTH(W)) lif ();

  clock_divider_prog #(
    .WIDTH(W),
    .DIV_DEFAULT(4),
    .HIGH_DEFAULT(2),
    .MODE_DEFAULT(0)
  ) dut (
    .Clk_in(clk),
    .Rst_n(rst_n),
    .Enable(en),
    .ld(lif),
    .Clk_out(clk_out),
    .Tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string ph;
    int    idx;
    byte   t;
    byte   c;
    byte   r;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  logic [1:0]   a_mode, b_mode;
  logic [W-1:0] a_div, b_div, a_high, b_high;

  task automatic chk(input string ph, input int idx, input string f,
                     input logic got, input byte want);
    if (want != "-") begin
      checks++;
      if (got !== (want == "1")) begin
        failures++;
        $display("FAIL %s[%0d] %s got=%b want=%s", ph, idx, f, got, want);
      end
    end
  endtask

  // Monitor: outputs are presented every cycle; compare at negedge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.ph, e.idx, "Tick", tick, e.t);
      chk(e.ph, e.idx, "Clk_out", clk_out, e.c);
      chk(e.ph, e.idx, "Load_ready", lif.Load_ready, e.r);
    end
  end

  task automatic push(input string ph, input int idx,
                      input byte t, input byte c, input byte r);
    exp_t e;
    e.ph  = ph;
    e.idx = idx;
    e.t   = t;
    e.c   = c;
    e.r   = r;
    q.push_back(e);
  endtask

  task automatic set_a(input logic [1:0] m, input int d, input int h);
    a_mode = m;
    a_div  = W'(d);
    a_high = W'(h);
  endtask

  task automatic set_b(input logic [1:0] m, input int d, input int h);
    b_mode = m;
    b_div  = W'(d);
    b_high = W'(h);
  endtask

  // One char per cycle: inputs for that cycle and outputs seen in it
  task automatic run(input string ph, input string e_s, input string l_s,
                     input string t_s, input string c_s, input string r_s);
    for (int i = 0; i < e_s.len(); i++) begin
      @(posedge clk);
      #1;
      push(ph, i, t_s[i], c_s[i], r_s[i]);
      en = (e_s[i] == "1");
      lif.Load_valid = 1'b0;
      if (l_s[i] == "a") begin
        lif.Load_valid = 1'b1;
        lif.Mode       = a_mode;
        lif.Div_in     = a_div;
        lif.High_in    = a_high;
      end else if (l_s[i] == "b") begin
        lif.Load_valid = 1'b1;
        lif.Mode       = b_mode;
        lif.Div_in     = b_div;
        lif.High_in    = b_high;
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    en             = 1'b0;
    lif.Load_valid = 1'b0;
    lif.Mode       = '0;
    lif.Div_in     = '0;
    lif.High_in    = '0;
    set_a(0, 0, 0);
    set_b(0, 0, 0);

    @(posedge clk);
    #1;
    push("reset", 0, "0", "0", "1");
    rst_n = 1'b1;

    run("dflt",
        "011111111111111111",
        "000000000000000000",
        "000001000100010001",
        "000001111000011110",
        "111111111111111111");

    set_a(1, 3, 0);
    run("pulse",
        "1111111111111",
        "a000000000000",
        "0001001001001",
        "0001001001001",
        "1001111111111");

    set_a(2, 10, 3);
    run("pwm3",
        "11111111111111111111111",
        "a0000000000000000000000",
        "00100000000010000000001",
        "00111000000011100000001",
        "10111111111111111111111");

    set_a(2, 10, 0);
    run("pwm0",
        "11111111111111111111",
        "a0000000000000000000",
        "00000000010000000001",
        "11000000000000000000",
        "10000000011111111111");

    set_a(2, 10, 12);
    run("pwm12",
        "11111111111111111111",
        "a0000000000000000000",
        "00000000010000000001",
        "00000000011111111111",
        "10000000011111111111");

    set_a(0, 5, 0);
    set_b(0, 7, 0);
    run("stall",
        "11111111111111111111111111111",
        "abbbbbbbbb0000000000000000000",
        "00000000010000100000010000001",
        "11111111100000111111100000001",
        "10000000010000111111111111111");

    set_a(0, 3, 0);
    run("ld_at_T",
        "11111111111111111111",
        "00000a00000000000000",
        "00000010000001001001",
        "11111100000001110001",
        "11111100000001111111");

    set_a(1, 0, 0);
    run("div0",
        "11111111",
        "a0000000",
        "00111111",
        "11111111",
        "10111111");

    set_a(0, 1, 0);
    run("div1",
        "11111111",
        "a0000000",
        "11111111",
        "11010101",
        "10111111");

    set_a(0, 6, 0);
    run("en_drop",
        "11111111110001111111",
        "a0000000000000000000",
        "11100000100000000001",
        "01000000111000000001",
        "10111111111111111111");

    set_a(1, 2, 0);
    run("dis_apply",
        "000011111",
        "0a0000000",
        "000000101",
        "100000101",
        "110111111");

    set_b(2, 9, 1);
    run("pend", "1", "b", "0", "0", "1");

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    lif.Load_valid = 1'b0;
    push("arst", 0, "0", "0", "1");
    @(posedge clk);
    #1;
    push("arst", 1, "0", "0", "1");
    rst_n = 1'b1;
    en    = 1'b1;

    run("post_rst",
        "11111111",
        "00000000",
        "00010001",
        "00011110",
        "11111111");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
